load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ALIGN_CHECK, default 1, meaning 1 = misaligned accesses are flagged and never reach memory; 0 = the address is forced to natural alignment (low bits ignored).
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline presents an access.
REQ-005 req_ready  output  1  unit can accept; an access transfers when req_valid && req_ready at posedge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load data; valid only with resp_valid && !req_we of the completing access.
REQ-012 resp_misaligned  output  1  qualifies resp_valid: alignment fault.
REQ-013 resp_illegal  output  1  qualifies resp_valid: unsupported funct3.
REQ-014 mem_addr  output  32  word address {addr[31:2],2'b00} to data memory.
REQ-015 mem_write_data  output  32  full word to data memory.
REQ-016 mem_read  output  1  read enable; memory returns data combinationally in the same cycle.
REQ-017 mem_write  output  1  word write enable; memory writes at posedge.
REQ-018 mem_read_data  input  32  word returned by memory.

Function
REQ-019 States: IDLE, MERGE; req_ready = 1 in IDLE, 0 in MERGE.
REQ-020 Legal loads (000, 001, 010, 100, 101): in the accept cycle assert mem_read, select the lane by addr[1:0], sign-extend (B, H) or zero-extend (BU, HU), register the result; resp_valid one cycle later (latency 1).
REQ-021 SW: in the accept cycle assert mem_write with req_wdata; resp_valid one cycle later.
REQ-022 SB/SH: in the accept cycle assert mem_read, merge req_wdata[7:0] or [15:0] into mem_read_data at the addressed lane, register the word and address, go to MERGE; in MERGE assert mem_write with the merged word, return to IDLE; resp_valid the cycle after MERGE (latency 2).
REQ-023 Misaligned access (H/HU/SH with addr[0] = 1; W/SW with addr[1:0] != 0), when ALIGN_CHECK = 1: no mem_read or mem_write; resp_valid with resp_misaligned = 1 one cycle later.
REQ-024 Illegal funct3 (loads 011/110/111; stores with funct3 >= 011): no memory access; resp_valid with resp_illegal = 1 one cycle later; resp_illegal takes priority over resp_misaligned.
REQ-025 resp_rdata is 0 on store, fault and illegal completions.
REQ-026 When no access is active, mem_read = mem_write = 0 and mem_addr = mem_write_data = 0.
REQ-027 Back-to-back accesses are accepted every cycle in IDLE; a completion pulse for the previous access may coincide with a new accept.
REQ-028 Req inputs are ignored while req_ready = 0; there is no response backpressure.

Reset
REQ-029 When rst_n is asserted, the unit enters IDLE and drives resp_valid, resp_misaligned, resp_illegal, mem_read and mem_write to 0, and resp_rdata and the merge registers to 0.
REQ-030 Reset during MERGE aborts the pending write; no mem_write and no resp_valid occur for that access.

Structure
REQ-031 The funct3 encodings and the state enumeration SHALL live in the shared CPU definitions package.
REQ-032 Lane extraction and sign extension SHALL be one combinational sub-module, load_align; everything else is flat.

Verification (memory word at 0x100 preloaded to 0x87654321)
REQ-033 LB 0x103 -> resp_rdata 0xFFFFFF87; LBU 0x103 -> 0x00000087; each completes 1 cycle after accept.
REQ-034 LH 0x102 -> 0xFFFF8765; LHU 0x100 -> 0x00004321.
REQ-035 SB 0x101, wdata 0xAA -> mem_read in cycle 0; mem_write 0x8765AA21 in cycle 1 with req_ready = 0; resp_valid in cycle 2.
REQ-036 LW 0x102 -> resp_misaligned = 1; mem_read and mem_write stay 0 throughout.
REQ-037 rst_n low during MERGE of SH 0x100, wdata 0xBEEF -> no mem_write and no resp_valid; word at 0x100 still reads 0x87654321.
REQ-038 SW 0x200 = 0x11223344 followed immediately by LW 0x200 -> resp_rdata 0x11223344 on the second completion.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared CPU definitions for the load/store path: RV32I width codes, LSU states
// and the store-lane merge helper used for sub-word read-modify-write.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } lsu_state_e;

    // Overlay the low byte/halfword of wdata onto word at the given lane.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  offset,
                                               input logic        half);
        logic [31:0] r;
        r = word;
        if (half)
            r[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        else
            r[{offset, 3'b000} +: 8] = wdata[7:0];
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational lane extraction and sign/zero extension of a memory word.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single-cycle loads and word stores, two-cycle
// read-modify-write for byte/halfword stores over a word-wide memory.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam bit CHECK = (ALIGN_CHECK != 0);

    lsu_state_e  state, state_next;
    logic        accept, is_half, is_word, illegal, misaligned, go, sub_store;
    logic [1:0]  offset;
    logic [31:0] word_addr, load_data;
    logic [31:0] merge_word_p1, merge_addr_p1;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign is_half   = (req_funct3[1:0] == 2'b01);
    assign is_word   = (req_funct3[1:0] == 2'b10);
    assign illegal   = req_we ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                              : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign misaligned = CHECK && !illegal &&
                        ((is_half && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00));
    assign go        = accept && !illegal && !misaligned;
    assign sub_store = req_we && !is_word;
    assign word_addr = {req_addr[31:2], 2'b00};

    // Low address bits are dropped to the natural alignment of the access size.
    assign offset = is_word ? 2'b00 : (is_half ? {req_addr[1], 1'b0} : req_addr[1:0]);

    load_align u_load_align (
        .word   (mem_read_data),
        .offset (offset),
        .funct3 (req_funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (go && sub_store) state_next = ST_MERGE;
            ST_MERGE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    mem_addr = word_addr;
                    if (req_we && is_word) begin
                        mem_write      = 1'b1;
                        mem_write_data = req_wdata;
                    end else begin
                        mem_read = 1'b1;
                    end
                end
            end
            ST_MERGE: begin
                mem_write      = 1'b1;
                mem_addr       = merge_addr_p1;
                mem_write_data = merge_word_p1;
            end
            default: ;
        endcase
    end

    // Response / merge stage: everything registered one cycle after the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_illegal    <= 1'b0;
            merge_word_p1   <= '0;
            merge_addr_p1   <= '0;
        end else begin
            resp_valid      <= (accept && !(go && sub_store)) || (state == ST_MERGE);
            resp_rdata      <= (go && !req_we) ? load_data : '0;
            resp_misaligned <= accept && misaligned;
            resp_illegal    <= accept && illegal;
            if (go && sub_store) begin
                merge_word_p1 <= merge_lane(mem_read_data, req_wdata, offset, is_half);
                merge_addr_p1 <= word_addr;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned, resp_illegal;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    logic [31:0] tb_mem  [1024];
    logic [31:0] ref_mem [1024];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ALIGN_CHECK(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .resp_illegal    (resp_illegal),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_read_data   (mem_read_data)
    );

    assign mem_read_data = mem_read ? tb_mem[mem_addr[11:2]] : 32'h0;

    always @(posedge clk)
        if (mem_write) tb_mem[mem_addr[11:2]] <= mem_write_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: RV32I semantics on a byte-addressed view of ref_mem.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic ill, output logic mis,
                         output logic [31:0] rd, output logic [31:0] merged, output int lat);
        int n, p, idx;
        longint v, word;
        ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        n   = 1 << f3[1:0];
        mis = !ill && ((addr % n) != 0);
        rd = 0; merged = 0; lat = 1;
        if (ill || mis) return;
        idx  = int'(addr[11:2]);
        p    = int'(addr % 4);
        word = longint'(ref_mem[idx]);
        if (!we) begin
            v = (word >> (8 * p)) & ((64'd1 << (8 * n)) - 1);
            if (!f3[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
            rd = v[31:0];
        end else begin
            for (int k = 0; k < n; k++)
                word = (word & ~(64'hFF << (8 * (p + k)))) |
                       (((longint'(wdata) >> (8 * k)) & 64'hFF) << (8 * (p + k)));
            merged = word[31:0];
            ref_mem[idx] = merged;
            lat = (n == 4) ? 1 : 2;
        end
    endtask

    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] obs_rdata,
                              output logic [31:0] obs_wword);
        logic ill, mis, ok, sub;
        logic [31:0] rd, merged, waddr;
        int lat;
        model(we, f3, addr, wdata, ill, mis, rd, merged, lat);
        ok    = !ill && !mis;
        sub   = (f3[1:0] != 2'b10);
        waddr = {addr[31:2], 2'b00};
        obs_wword = 32'h0;
        @(negedge clk);
        check_eq("idle_resp", resp_valid, 0);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        #1;
        check_eq("ready", req_ready, 1);
        check_eq("acc_rd", mem_read, ok && (!we || sub));
        check_eq("acc_wr", mem_write, ok && we && !sub);
        check_eq("acc_addr", mem_addr, ok ? waddr : 32'h0);
        check_eq("acc_wdata", mem_write_data, (ok && we && !sub) ? wdata : 32'h0);
        if (ok && we && !sub) obs_wword = mem_write_data;
        @(negedge clk);
        req_valid = 0;
        #1;
        if (lat == 2) begin
            check_eq("mrg_ready", req_ready, 0);
            check_eq("mrg_resp", resp_valid, 0);
            check_eq("mrg_wr", mem_write, 1);
            check_eq("mrg_rd", mem_read, 0);
            check_eq("mrg_addr", mem_addr, waddr);
            check_eq("mrg_word", mem_write_data, merged);
            obs_wword = mem_write_data;
            @(negedge clk);
            #1;
        end
        check_eq("resp_valid", resp_valid, 1);
        check_eq("resp_rdata", resp_rdata, rd);
        check_eq("resp_mis", resp_misaligned, mis);
        check_eq("resp_ill", resp_illegal, ill);
        check_eq("resp_rd", mem_read, 0);
        check_eq("resp_wr", mem_write, 0);
        obs_rdata = resp_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, w;
        logic ill, mis;
        logic [31:0] rd, merged;
        int lat;
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = (i * 32'h01030507) ^ 32'h5A5A5A5A;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[32'h100 >> 2]  = 32'h87654321;
        ref_mem[32'h100 >> 2] = 32'h87654321;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rst_n = 0;
        #1;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_resp", resp_valid, 0);
        check_eq("rst_rdata", resp_rdata, 0);
        check_eq("rst_flags", {resp_misaligned, resp_illegal}, 0);
        check_eq("rst_mem", {mem_read, mem_write}, 0);
        check_eq("rst_maddr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        run_access(0, 3'b000, 32'h103, 0, r, w); check_eq("lb_103", r, 32'hFFFFFF87);
        run_access(0, 3'b100, 32'h103, 0, r, w); check_eq("lbu_103", r, 32'h00000087);
        run_access(0, 3'b001, 32'h102, 0, r, w); check_eq("lh_102", r, 32'hFFFF8765);
        run_access(0, 3'b101, 32'h100, 0, r, w); check_eq("lhu_100", r, 32'h00004321);
        run_access(0, 3'b010, 32'h102, 0, r, w); check_eq("lw_mis", resp_misaligned, 1);
        run_access(0, 3'b011, 32'h101, 0, r, w); check_eq("ld_ill", resp_illegal, 1);

        // Reset while the SH merge write is pending.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = 3'b001; req_addr = 32'h100; req_wdata = 32'hBEEF;
        @(negedge clk);
        req_valid = 0;
        #1;
        check_eq("sh_merge_wr", mem_write, 1);
        rst_n = 0;
        #1;
        check_eq("abort_wr", mem_write, 0);
        check_eq("abort_ready", req_ready, 1);
        @(negedge clk);
        #1;
        check_eq("abort_resp", resp_valid, 0);
        rst_n = 1;
        run_access(0, 3'b010, 32'h100, 0, r, w); check_eq("lw_after_abort", r, 32'h87654321);

        run_access(1, 3'b000, 32'h101, 32'hAA, r, w); check_eq("sb_101_word", w, 32'h8765AA21);

        // SW then LW back to back; SW completion overlaps the LW accept.
        model(1, 3'b010, 32'h200, 32'h11223344, ill, mis, rd, merged, lat);
        model(0, 3'b010, 32'h200, 0, ill, mis, rd, merged, lat);
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h11223344;
        #1;
        check_eq("b2b_sw_wr", mem_write, 1);
        @(negedge clk);
        req_we = 0; req_wdata = 0;
        #1;
        check_eq("b2b_sw_resp", resp_valid, 1);
        check_eq("b2b_sw_rdata", resp_rdata, 0);
        check_eq("b2b_lw_rd", mem_read, 1);
        @(negedge clk);
        req_valid = 0;
        #1;
        check_eq("b2b_lw_resp", resp_valid, 1);
        check_eq("b2b_lw_rdata", resp_rdata, rd);
        check_eq("b2b_lw_const", resp_rdata, 32'h11223344);

        for (int t = 0; t < 300; t++)
            run_access(1'($urandom % 2), 3'($urandom % 8), 32'h100 + $urandom_range(0, 63),
                       $urandom, r, w);

        @(negedge clk);
        for (int i = 32'h100 >> 2; i < (32'h140 >> 2); i++)
            check_eq("mem_final", tb_mem[i], ref_mem[i]);
        check_eq("mem_final_200", tb_mem[32'h200 >> 2], ref_mem[32'h200 >> 2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
